audio_fingerprint_recorder: RTL and testbench
=============================================

# audio_fingerprint_recorder

Captures a fixed-length, decimated window of the incoming audio stream into one of two sample slots, starting at a loudness onset. It sits directly upstream of the sample comparator. It produces the two 50-entry, 20-bit stored-sample arrays that the comparator scores, plus per-slot done flags so comparison only runs on complete captures.

## Interface
Parameters:
- SAMPLE_W, 20, audio sample width (two's complement)
- NUM_SAMPLES, 50, entries per slot
- DECIM, 16, store one of every DECIM valid input samples after the trigger
- TRIG_LEVEL, 4096, onset threshold on |sample|

Ports:
- clk  in  1  single system clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- sample_in  in  SAMPLE_W  signed audio sample
- sample_valid  in  1  sample_in valid this cycle
- record_SW  in  1  level switch; rising edge starts a capture, low aborts it
- slot_sel  in  1  0 selects slot 1, 1 selects slot 2; sampled on the start edge
- busy  out  1  high in ARM or CAPTURE
- done_1, done_2  out  1  slot holds a complete capture
- capture_count  out  6  entries written in the current capture
- stored_sample_1, stored_sample_2  out  SAMPLE_W x NUM_SAMPLES  unpacked arrays [NUM_SAMPLES-1:0]

## Operation
- Reset values: state IDLE, all array entries 0, done_1 = done_2 = 0, busy = 0, capture_count = 0, decimation counter 0.
- record_SW is registered into record_q, which resets to 1. This prevents a spurious start if the switch is high at reset release.
- start = record_SW & ~record_q.
- State IDLE:
  - On start, latch slot_sel into active_slot.
  - Clear the done flag of the active slot, clear capture_count, and go to ARM.
- State ARM:
  - On a valid sample with abs(sample_in) >= TRIG_LEVEL, write that sample to entry 0 of the active slot.
  - Set capture_count = 1, set the decimation counter to 0, and go to CAPTURE.
- State CAPTURE:
  - Each valid sample increments the decimation counter, which runs 0..DECIM-1 and wraps.
  - When the counter wraps to 0, that sample is written to entry capture_count, and capture_count increments.
  - Result: entry k holds the valid sample k*DECIM after the trigger (the trigger sample counts as 0).
  - After the write of entry NUM_SAMPLES-1, go to DONE.
- State DONE:
  - Assert the active slot's done flag.
  - Return to IDLE immediately. A new capture needs a fresh rising edge.
- Abort: record_SW low in ARM or CAPTURE returns the block to IDLE.
  - The active slot's done flag stays 0.
  - Entries already written keep their new values; nothing further is written.
- The inactive slot, including its array and done flag, is never modified during a capture.
- abs() rule:
  - The most negative input (-2^(SAMPLE_W-1)) saturates to 2^(SAMPLE_W-1)-1.
  - The threshold compare is unsigned on SAMPLE_W bits.
- Cycles with sample_valid low cause no state or counter change.

## Timing
- All array writes land on the clock edge at which sample_valid is high; the new value is visible on the outputs the following cycle.
- done_x rises one cycle after the final entry write (DONE state cycle). busy falls in that same cycle.
- start is recognised one cycle after record_SW rises. A sample that is valid in the edge cycle is not considered for triggering.
- A trigger check and a write never share a cycle for the same sample. In ARM the trigger sample itself is entry 0.
- Abort has priority over a write in the same cycle: if record_SW is low, no write occurs.
- rst mid-capture clears everything immediately (asynchronous), including previously completed slots.
- Sustained input at one valid per cycle: a full capture takes 1 + (NUM_SAMPLES-1)*DECIM valid cycles after the trigger, i.e. 785 with the defaults.

## Structure
- Package audio_fp_pkg holds:
  - SAMPLE_W and NUM_SAMPLES constants
  - typedef sample_t = logic signed [SAMPLE_W-1:0]
  - the state enum rec_state_t {IDLE, ARM, CAPTURE, DONE}
- The comparator imports the same package for its array widths.
- One sub-module, onset_detect: combinational saturating abs plus threshold compare, outputting a single trigger bit. It is reused later for silence detection.

## Test plan
- Reset then record_SW high, slot_sel 0, inputs ramp 0,1,2,... with valid every cycle, TRIG_LEVEL 4096 -> trigger at 4096. stored_sample_1[k] = 4096 + 16k for k = 0..49. done_1 rises one cycle after the 50th write. stored_sample_2 stays all 0.
- Sample -4096 in ARM -> triggers. Sample -2^19 -> triggers (saturated abs). Sample 4095 -> no trigger.
- record_SW dropped after 10 entries -> busy = 0, done_1 = 0, entries 0..9 hold the new data and entries 10..49 hold the old data. Re-raising the switch starts a new ARM.
- Capture slot 2 with sample_valid toggling every other cycle -> same stored values as the continuous case. done_2 = 1, and slot 1 contents and done_1 unchanged.
- record_SW held high through reset release -> no capture starts. Then low, then high -> capture starts.
- rst asserted mid-CAPTURE with done_1 = 1 -> all arrays 0, both done flags 0, state IDLE in the same cycle.

Source files
------------

// File: rtl/audio_fingerprint_recorder_pkg.sv
// Shared constants and types for the audio fingerprint recorder and the
// downstream sample comparator that scores its two capture slots.
package audio_fp_pkg;

   localparam int SAMPLE_W    = 20;
   localparam int NUM_SAMPLES = 50;
   localparam int CNT_W       = 6;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } rec_state_t;

endpackage

// File: rtl/audio_fingerprint_recorder_onset_detect.sv
// Combinational loudness onset detector: saturating |sample| compared against
// a fixed threshold. Also intended for silence detection elsewhere.
module onset_detect #(
   parameter int SAMPLE_W   = audio_fp_pkg::SAMPLE_W,
   parameter int TRIG_LEVEL = 4096
) (
   input  logic [SAMPLE_W-1:0] sample_in,
   output logic                trig
);

   localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
   localparam logic [SAMPLE_W-1:0] TRIG_V   = SAMPLE_W'(TRIG_LEVEL);

   logic [SAMPLE_W-1:0] abs_s;

   // Saturating magnitude; the most negative code has no positive twin.
   always_comb begin
      if (sample_in == MOST_NEG) begin
         abs_s = ~MOST_NEG;
      end else if (sample_in[SAMPLE_W-1]) begin
         abs_s = (~sample_in) + SAMPLE_W'(1);
      end else begin
         abs_s = sample_in;
      end
      trig = (abs_s >= TRIG_V);
   end

endmodule

// File: rtl/audio_fingerprint_recorder.sv
// Onset-triggered, decimated capture of the audio stream into one of two
// sample slots, with per-slot completion flags for the comparator.
module audio_fingerprint_recorder #(
   parameter int SAMPLE_W    = audio_fp_pkg::SAMPLE_W,
   parameter int NUM_SAMPLES = audio_fp_pkg::NUM_SAMPLES,
   parameter int DECIM       = 16,
   parameter int TRIG_LEVEL  = 4096
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   input  logic                record_SW,
   input  logic                slot_sel,
   output logic                busy,
   output logic                done_1,
   output logic                done_2,
   output logic [5:0]          capture_count,
   output logic [SAMPLE_W-1:0] stored_sample_1 [NUM_SAMPLES-1:0],
   output logic [SAMPLE_W-1:0] stored_sample_2 [NUM_SAMPLES-1:0]
);

   import audio_fp_pkg::*;

   localparam int DECIM_W = (DECIM > 1) ? $clog2(DECIM) : 1;

   rec_state_t          state_q, state_d;
   logic                record_q, record_d;
   logic                active_slot_q, active_slot_d;
   logic [DECIM_W-1:0]  decim_q, decim_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                done1_q, done1_d;
   logic                done2_q, done2_d;
   logic                busy_q, busy_d;
   logic [SAMPLE_W-1:0] mem1_q [NUM_SAMPLES-1:0];
   logic [SAMPLE_W-1:0] mem1_d [NUM_SAMPLES-1:0];
   logic [SAMPLE_W-1:0] mem2_q [NUM_SAMPLES-1:0];
   logic [SAMPLE_W-1:0] mem2_d [NUM_SAMPLES-1:0];

   logic                start_s;
   logic                trig_s;
   logic                wr_en_s;
   logic [CNT_W-1:0]    wr_idx_s;

   onset_detect #(
      .SAMPLE_W   (SAMPLE_W),
      .TRIG_LEVEL (TRIG_LEVEL)
   ) u_onset (
      .sample_in (sample_in),
      .trig      (trig_s)
   );

   // Capture sequencing: start edge, trigger, decimated writes, abort, completion.
   always_comb begin
      record_d      = record_SW;
      start_s       = record_SW & ~record_q;
      state_d       = state_q;
      active_slot_d = active_slot_q;
      decim_d       = decim_q;
      count_d       = count_q;
      done1_d       = done1_q;
      done2_d       = done2_q;
      wr_en_s       = 1'b0;
      wr_idx_s      = count_q;

      case (state_q)
         IDLE: begin
            if (start_s) begin
               active_slot_d = slot_sel;
               if (slot_sel) begin
                  done2_d = 1'b0;
               end else begin
                  done1_d = 1'b0;
               end
               count_d = '0;
               state_d = ARM;
            end else begin
               state_d = IDLE;
            end
         end
         ARM: begin
            if (!record_SW) begin
               state_d = IDLE;
            end else if (sample_valid && trig_s) begin
               wr_en_s  = 1'b1;
               wr_idx_s = '0;
               count_d  = CNT_W'(1);
               decim_d  = '0;
               state_d  = CAPTURE;
            end else begin
               state_d = ARM;
            end
         end
         CAPTURE: begin
            if (!record_SW) begin
               state_d = IDLE;
            end else if (sample_valid) begin
               if (decim_q == DECIM_W'(DECIM - 1)) begin
                  decim_d  = '0;
                  wr_en_s  = 1'b1;
                  wr_idx_s = count_q;
                  count_d  = count_q + CNT_W'(1);
                  // Flag completion on the final write so it is visible in the DONE cycle.
                  if (count_q == CNT_W'(NUM_SAMPLES - 1)) begin
                     if (active_slot_q) begin
                        done2_d = 1'b1;
                     end else begin
                        done1_d = 1'b1;
                     end
                     state_d = DONE;
                  end else begin
                     state_d = CAPTURE;
                  end
               end else begin
                  decim_d = decim_q + DECIM_W'(1);
                  state_d = CAPTURE;
               end
            end else begin
               state_d = CAPTURE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == ARM) || (state_d == CAPTURE);
   end

   // Slot array write steering; only the active slot is ever touched.
   always_comb begin
      mem1_d = mem1_q;
      mem2_d = mem2_q;
      if (wr_en_s) begin
         if (active_slot_q) begin
            mem2_d[wr_idx_s] = sample_in;
         end else begin
            mem1_d[wr_idx_s] = sample_in;
         end
      end else begin
         mem1_d = mem1_q;
      end
   end

   // Control registers; record_q resets high so a held switch cannot start a capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         record_q      <= 1'b1;
         active_slot_q <= 1'b0;
         decim_q       <= '0;
         count_q       <= '0;
         done1_q       <= 1'b0;
         done2_q       <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         record_q      <= record_d;
         active_slot_q <= active_slot_d;
         decim_q       <= decim_d;
         count_q       <= count_d;
         done1_q       <= done1_d;
         done2_q       <= done2_d;
         busy_q        <= busy_d;
      end
   end

   // Sample slot storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_SAMPLES; i++) begin
            mem1_q[i] <= '0;
            mem2_q[i] <= '0;
         end
      end else begin
         mem1_q <= mem1_d;
         mem2_q <= mem2_d;
      end
   end

   assign busy            = busy_q;
   assign done_1          = done1_q;
   assign done_2          = done2_q;
   assign capture_count   = count_q;
   assign stored_sample_1 = mem1_q;
   assign stored_sample_2 = mem2_q;

endmodule

// File: tb/tb_audio_fingerprint_recorder.sv
// Self-checking bench for audio_fingerprint_recorder: trigger vector table,
// ramp/abort/toggle/reset sequences and randomized captures vs. a batch model.
module tb_audio_fingerprint_recorder;

   localparam int SW   = 20;
   localparam int NS   = 50;
   localparam int DEC  = 16;
   localparam int TRIG = 4096;
   localparam int MAXL = 10000;

   logic          clk = 1'b0;
   logic          rst;
   logic [SW-1:0] sample_in;
   logic          sample_valid;
   logic          record_SW;
   logic          slot_sel;
   logic          busy, done_1, done_2;
   logic [5:0]    capture_count;
   logic [SW-1:0] ss1 [NS-1:0];
   logic [SW-1:0] ss2 [NS-1:0];

   int n_tests = 0;
   int n_fail  = 0;

   logic [SW-1:0] mdl1 [NS];
   logic [SW-1:0] mdl2 [NS];
   bit            mdone1, mdone2;

   bit            rec_g [MAXL];
   bit            vld_g [MAXL];
   logic [SW-1:0] smp_g [MAXL];

   typedef struct packed {
      logic [SW-1:0] smp;
      logic          trig;
   } trig_vec_t;

   trig_vec_t vecs [9];

   always #5 clk = ~clk;

   audio_fingerprint_recorder dut (
      .clk             (clk),
      .rst             (rst),
      .sample_in       (sample_in),
      .sample_valid    (sample_valid),
      .record_SW       (record_SW),
      .slot_sel        (slot_sel),
      .busy            (busy),
      .done_1          (done_1),
      .done_2          (done_2),
      .capture_count   (capture_count),
      .stored_sample_1 (ss1),
      .stored_sample_2 (ss2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   function automatic int abs_ref(input logic [SW-1:0] v);
      int x;
      x = int'($signed(v));
      if (x < 0) x = -x;
      if (x > (1 << (SW - 1)) - 1) x = (1 << (SW - 1)) - 1;
      return x;
   endfunction

   task automatic check_arrays(input string tag);
      for (int k = 0; k < NS; k++) begin
         chk({tag, "_slot1"}, k, 32'(ss1[k]), 32'(mdl1[k]));
         chk({tag, "_slot2"}, k, 32'(ss2[k]), 32'(mdl2[k]));
      end
      chk({tag, "_done1"}, 0, 32'(done_1), 32'(mdone1));
      chk({tag, "_done2"}, 0, 32'(done_2), 32'(mdone2));
   endtask

   // Ramp stimulus: value advances once per valid sample; invalid cycles carry junk.
   task automatic gen_ramp(input int L, input int base, input bit neg, input bit toggle, input int low_from);
      int r;
      r = base;
      for (int i = 0; i < L; i++) begin
         rec_g[i] = (i >= 1) && (i < low_from);
         if (!toggle || (i % 2 == 0)) begin
            vld_g[i] = 1'b1;
            smp_g[i] = SW'(neg ? -r : r);
            r++;
         end else begin
            vld_g[i] = 1'b0;
            smp_g[i] = SW'($urandom);
         end
      end
   endtask

   task automatic gen_random(input int L, input int low_from);
      for (int i = 0; i < L; i++) begin
         rec_g[i] = (i >= 1) && (i < low_from);
         vld_g[i] = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 39))
            0:       smp_g[i] = SW'($urandom);
            1:       smp_g[i] = SW'(TRIG);
            2:       smp_g[i] = SW'(-TRIG);
            3:       smp_g[i] = SW'(TRIG - 1);
            default: smp_g[i] = SW'(int'($urandom_range(0, 8190)) - 4095);
         endcase
      end
   endtask

   // Expected results derived from the list of valid samples after the trigger:
   // entry k is valid sample k*DEC after (and counting) the trigger sample.
   task automatic run_scenario(input int L, input logic slot, input string tag);
      int s, a, t, nw, e, c;
      int wcyc [NS];
      int vq [$];
      bit complete;
      s = L;
      for (int i = 1; i < L; i++)
         if (s == L && rec_g[i] && !rec_g[i-1]) s = i;
      a = L;
      for (int i = s + 1; i < L; i++)
         if (a == L && !rec_g[i]) a = i;
      t = -1;
      for (int i = s + 1; i < a; i++)
         if (t < 0 && vld_g[i] && abs_ref(smp_g[i]) >= TRIG) t = i;
      vq.delete();
      if (t >= 0)
         for (int i = t; i < a; i++)
            if (vld_g[i]) vq.push_back(i);
      nw = 0;
      for (int k = 0; k < NS; k++)
         if (k * DEC < vq.size()) begin
            wcyc[k] = vq[k * DEC];
            nw = k + 1;
         end
      complete = (nw == NS);
      e = complete ? wcyc[NS-1] : a;
      for (int k = 0; k < nw; k++) begin
         if (slot) mdl2[k] = smp_g[wcyc[k]];
         else      mdl1[k] = smp_g[wcyc[k]];
      end
      if (slot) mdone2 = complete;
      else      mdone1 = complete;

      c = 0;
      for (int i = 0; i < L; i++) begin
         record_SW    = rec_g[i];
         sample_valid = vld_g[i];
         sample_in    = smp_g[i];
         slot_sel     = (i == s) ? slot : 1'($urandom_range(0, 1));
         tick();
         if (i >= s) begin
            while (c < nw && wcyc[c] <= i) c++;
            chk({tag, "_busy"}, i, 32'(busy), (i < e) ? 32'd1 : 32'd0);
            chk({tag, "_count"}, i, 32'(capture_count), 32'(c));
            chk({tag, "_done"}, i, slot ? 32'(done_2) : 32'(done_1),
                (complete && i >= wcyc[NS-1]) ? 32'd1 : 32'd0);
         end
      end
      check_arrays(tag);
   endtask

   initial begin
      logic [SW-1:0] ev;

      vecs[0] = '{smp: 20'h01000, trig: 1'b1};
      vecs[1] = '{smp: 20'hFF000, trig: 1'b1};
      vecs[2] = '{smp: 20'h80000, trig: 1'b1};
      vecs[3] = '{smp: 20'h00FFF, trig: 1'b0};
      vecs[4] = '{smp: 20'hFF001, trig: 1'b0};
      vecs[5] = '{smp: 20'h7FFFF, trig: 1'b1};
      vecs[6] = '{smp: 20'h00000, trig: 1'b0};
      vecs[7] = '{smp: 20'h01001, trig: 1'b1};
      vecs[8] = '{smp: 20'hFEFFF, trig: 1'b1};

      for (int k = 0; k < NS; k++) begin
         mdl1[k] = '0;
         mdl2[k] = '0;
      end
      mdone1 = 1'b0;
      mdone2 = 1'b0;

      // Reset with the switch already high.
      rst = 1'b1; record_SW = 1'b1; sample_valid = 1'b0; sample_in = '0; slot_sel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      chk("reset_busy", 0, 32'(busy), 32'd0);
      chk("reset_count", 0, 32'(capture_count), 32'd0);
      check_arrays("reset");

      for (int i = 0; i < 20; i++) begin
         sample_valid = 1'b1;
         sample_in    = SW'(300000);
         tick();
         chk("held_sw_busy", i, 32'(busy), 32'd0);
         chk("held_sw_count", i, 32'(capture_count), 32'd0);
      end

      // Trigger threshold table; the edge-cycle sample is loud but must be ignored.
      for (int v = 0; v < 9; v++) begin
         record_SW = 1'b0; sample_valid = 1'b0; tick();
         record_SW = 1'b1; sample_valid = 1'b1; sample_in = SW'(300000); slot_sel = 1'b0; tick();
         chk("vec_arm_busy", v, 32'(busy), 32'd1);
         chk("vec_arm_count", v, 32'(capture_count), 32'd0);
         sample_in = vecs[v].smp; slot_sel = 1'b1; tick();
         mdone1 = 1'b0;
         if (vecs[v].trig) mdl1[0] = vecs[v].smp;
         chk("vec_count", v, 32'(capture_count), vecs[v].trig ? 32'd1 : 32'd0);
         chk("vec_entry0", v, 32'(ss1[0]), 32'(mdl1[0]));
         record_SW = 1'b0; sample_in = SW'(300000); tick();
         chk("vec_abort_busy", v, 32'(busy), 32'd0);
         chk("vec_abort_done1", v, 32'(done_1), 32'd0);
      end
      check_arrays("vectors");

      // Continuous ramp into slot 1.
      gen_ramp(4890, 0, 1'b0, 1'b0, 4887);
      run_scenario(4890, 1'b0, "ramp");
      for (int k = 0; k < NS; k++)
         chk("ramp_value", k, 32'(ss1[k]), 32'(4096 + 16 * k));

      // Negative ramp into slot 1, aborted right after entry 9.
      gen_ramp(4250, 0, 1'b1, 1'b0, 4241);
      run_scenario(4250, 1'b0, "abort");
      for (int k = 0; k < NS; k++) begin
         ev = (k < 10) ? SW'(-(4096 + 16 * k)) : SW'(4096 + 16 * k);
         chk("abort_value", k, 32'(ss1[k]), 32'(ev));
      end

      // Slot 2 with valid every other cycle.
      gen_ramp(9770, 0, 1'b0, 1'b1, 9767);
      run_scenario(9770, 1'b1, "toggle");
      for (int k = 0; k < NS; k++)
         chk("toggle_value", k, 32'(ss2[k]), 32'(4096 + 16 * k));

      for (int r = 0; r < 4; r++) begin
         gen_random(1300, (r % 2 == 0) ? 1297 : int'($urandom_range(200, 1000)));
         run_scenario(1300, 1'($urandom_range(0, 1)), "rand");
      end

      gen_ramp(891, 4000, 1'b0, 1'b0, 888);
      run_scenario(891, 1'b0, "ramp2");

      // Asynchronous reset in the middle of a slot 2 capture.
      record_SW = 1'b0; sample_valid = 1'b0; tick();
      record_SW = 1'b1; slot_sel = 1'b1; sample_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         sample_in = SW'(5000 + i);
         tick();
      end
      chk("mid_busy", 0, 32'(busy), 32'd1);
      chk("mid_done1", 0, 32'(done_1), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      for (int k = 0; k < NS; k++) begin
         mdl1[k] = '0;
         mdl2[k] = '0;
      end
      mdone1 = 1'b0;
      mdone2 = 1'b0;
      chk("rst_busy", 0, 32'(busy), 32'd0);
      chk("rst_count", 0, 32'(capture_count), 32'd0);
      check_arrays("rst_mid");
      tick();
      rst = 1'b0; record_SW = 1'b0;
      tick();
      chk("post_rst_busy", 0, 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
